// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent rising-edge JK flip-flops with synchronous reset and complementary outputs.
// Define JK_FF_ASSERT_EN to compile in simulation-only consistency checks.
module jk_flip_flop #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_b
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  function automatic logic jk_next(input logic q_cur, input logic j_b, input logic k_b);
    logic nxt;
    case ({j_b, k_b})
      2'b00:   nxt = q_cur;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11:   nxt = ~q_cur;
      default: nxt = q_cur;
    endcase
    return nxt;
  endfunction

  // Next-state: reset overrides, otherwise each bit follows its own JK pair.
  always_comb begin
    q_d = q_q;
    if (rst) begin
      q_d = RESET_VAL;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        q_d[i] = jk_next(q_q[i], j[i], k[i]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  // Q_b is derived from the same register so the pair can never disagree.
  assign Q   = q_q;
  assign Q_b = ~q_q;

`ifdef JK_FF_ASSERT_EN
  logic             chk_seen_q;
  logic             chk_rst_q;
  logic [WIDTH-1:0] chk_j_q;
  logic [WIDTH-1:0] chk_k_q;
  logic [WIDTH-1:0] chk_prev_q;

  // Capture the inputs and pre-edge state, then check the result one edge later.
  always_ff @(posedge clk) begin
    assert (Q_b === ~Q) else $error("jk_flip_flop: Q_b %b is not ~Q %b", Q_b, Q);
    if (chk_seen_q === 1'b1) begin
      if (chk_rst_q) begin
        assert (Q === RESET_VAL) else $error("jk_flip_flop: Q %b after reset, want %b", Q, RESET_VAL);
      end else begin
        assert (Q === ((chk_j_q & ~chk_prev_q) | (~chk_k_q & chk_prev_q)))
          else $error("jk_flip_flop: Q %b violates JK table", Q);
      end
    end else begin
      assert (1'b1);
    end
    chk_rst_q  <= rst;
    chk_j_q    <= j;
    chk_k_q    <= k;
    chk_prev_q <= Q;
    if (rst) begin
      chk_seen_q <= 1'b1;
    end else begin
      chk_seen_q <= chk_seen_q;
    end
  end
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed plus randomized bench for jk_flip_flop (WIDTH=1 default and WIDTH=4, RESET_VAL=4'b1010).
module tb_jk_flip_flop;

  logic       clk = 1'b0;
  logic       rst;
  logic       j1, k1;
  logic       q1, qb1;
  logic [3:0] j4, k4;
  logic [3:0] q4, qb4;

  int tests = 0;
  int fails = 0;

  logic       m1;
  logic [3:0] m4;

  always #5 clk = ~clk;

  jk_flip_flop u_dut1 (
    .j(j1), .k(k1), .clk(clk), .rst(rst), .Q(q1), .Q_b(qb1)
  );

  jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
    .j(j4), .k(k4), .clk(clk), .rst(rst), .Q(q4), .Q_b(qb4)
  );

  // Reference: the JK truth table stated as rules.
  function automatic logic ref_bit(input logic q, input logic jj, input logic kk);
    if (!jj && !kk) return q;
    else if (!jj)   return 1'b0;
    else if (!kk)   return 1'b1;
    else            return !q;
  endfunction

  task automatic check(input string tag);
    tests++;
    assert (q1 === m1) else begin
      fails++; $error("FAIL %s Q1 got %b expected %b", tag, q1, m1);
    end
    tests++;
    assert (qb1 === ~m1) else begin
      fails++; $error("FAIL %s Qb1 got %b expected %b", tag, qb1, ~m1);
    end
    tests++;
    assert (q4 === m4) else begin
      fails++; $error("FAIL %s Q4 got %b expected %b", tag, q4, m4);
    end
    tests++;
    assert (qb4 === ~m4) else begin
      fails++; $error("FAIL %s Qb4 got %b expected %b", tag, qb4, ~m4);
    end
  endtask

  task automatic step(input logic r, input logic jj1, input logic kk1,
                      input logic [3:0] jj4, input logic [3:0] kk4, input string tag);
    @(negedge clk);
    rst = r; j1 = jj1; k1 = kk1; j4 = jj4; k4 = kk4;
    @(posedge clk);
    if (r) begin
      m1 = 1'b0;
      m4 = 4'b1010;
    end else begin
      m1 = ref_bit(m1, jj1, kk1);
      for (int i = 0; i < 4; i++) m4[i] = ref_bit(m4[i], jj4[i], kk4[i]);
    end
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b0; j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    m1 = 1'bx; m4 = 4'bxxxx;

    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, "reset");
    tests++;
    assert (q1 === 1'b0 && qb1 === 1'b1 && q4 === 4'b1010) else begin
      fails++; $error("FAIL reset_const Q1 %b Q4 %b expected 0 and 1010", q1, q4);
    end
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "hold0_a");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "hold0_b");
    step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, "set");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "hold1_a");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, "hold1_b");
    step(1'b0, 1'b1, 1'b0, 4'b0101, 4'b0000, "reset_set");
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111, "kreset");
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, "toggle");
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, "toggle_pre");
    step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111, "rst_priority");
    step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, "toggle_resume");
    tests++;
    assert (q1 === 1'b1 && q4 === 4'b0101) else begin
      fails++; $error("FAIL resume_const Q1 %b Q4 %b expected 1 and 0101", q1, q4);
    end

    // Vector mix: hold, K-reset, J-set and toggle in one edge from 1010.
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, "vec_reset");
    step(1'b0, 1'b0, 1'b0, 4'b0011, 4'b0101, "vec_mix");
    tests++;
    assert (q4 === 4'b1011 && qb4 === 4'b0100) else begin
      fails++; $error("FAIL vec_const Q4 %b Qb4 %b expected 1011 0100", q4, qb4);
    end

    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
